// File: rtl/maze_pkg.sv
// Shared definitions for the maze generator and the VGA maze renderer.
// Holds the bitmap geometry, FSM state codes, LFSR constants and the
// tile-to-bit-index mapping that both sides of the path bitmap must agree on.
package maze_pkg;

    // Side length of the square path bitmap, in tiles.
    localparam int MAZE_DIM = 64;

    // Galois LFSR feedback mask (shift right, bit 0 fed back).
    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    // Load value used when the requested seed is zero (an all-zero LFSR would lock up).
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Generator FSM state codes.
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_CLEAR = 2'd1;
    localparam state_t S_CARVE = 2'd2;
    localparam state_t S_DONE  = 2'd3;

    // Bit index of tile (x, y) in the flattened bitmap.
    function automatic logic [11:0] tile_idx(input logic [5:0] x, input logic [5:0] y);
        return 12'(x) + 12'(MAZE_DIM) * 12'(y);
    endfunction

    // A grid dimension is usable when it is odd and within 3..63.
    function automatic logic dim_ok(input logic [6:0] d);
        return d[0] && (d >= 7'd3) && !d[6];
    endfunction

endpackage

// File: rtl/maze_generator_lfsr16.sv
// lfsr16: 16-bit right-shifting Galois LFSR that drives the maze wall choice.
// Latency: load/step take effect at the next clock edge; q is registered.
// Backpressure: none; the caller asserts step only on cycles that consume a bit.
// Ports: clk, reset (sync, active low), load/load_val (priority over step),
//        step (advance one position), q (current state).
module lfsr16
    import maze_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        step,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (step) begin
            q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? LFSR_MASK : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q <= DEFAULT_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/maze_generator.sv
// maze_generator: clears the 64x64 path bitmap then carves a binary-tree maze.
// Latency: 64 clear cycles + one cycle per cell, then a one-cycle done pulse.
// Backpressure: none; start is ignored while busy or in DONE.
// Ports: clk, reset (sync, active low), start, width_in/height_in/seed (sampled
//        on an accepted start), path_data (registered bitmap), maze_width,
//        maze_height, busy, done, err.
// Build option: define MAZE_EXIT_EN to open an entrance at (0,1) and an exit at
//        (maze_width-1, maze_height-2) in the DONE cycle.
module maze_generator
    import maze_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [6:0]    width_in,
    input  logic [6:0]    height_in,
    input  logic [15:0]   seed,
    output logic [4095:0] path_data,
    output logic [6:0]    maze_width,
    output logic [6:0]    maze_height,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t        state_q, state_d;
    logic [5:0]    row_q, row_d;
    logic [4:0]    cx_q, cx_d;
    logic [4:0]    cy_q, cy_d;
    logic [6:0]    width_q, width_d;
    logic [6:0]    height_q, height_d;
    logic [4095:0] path_q, path_d;
    logic          err_q, err_d;
    logic          done_q, done_d;

    logic          lfsr_load;
    logic          lfsr_step;
    logic [15:0]   lfsr_q;
    logic          north_sel;

    // Last cell index in each direction: (dim-1)/2 - 1, dims are odd and < 64.
    logic [4:0]    cx_last;
    logic [4:0]    cy_last;

    assign cx_last   = width_q[5:1] - 5'd1;
    assign cy_last   = height_q[5:1] - 5'd1;
    // Only bit 0 of the LFSR steers the wall choice.
    assign north_sel = |(lfsr_q & 16'h0001);

    lfsr16 u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (lfsr_load),
        .load_val ((seed == 16'h0000) ? DEFAULT_SEED : seed),
        .step     (lfsr_step),
        .q        (lfsr_q)
    );

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        width_d   = width_q;
        height_d  = height_q;
        path_d    = path_q;
        err_d     = err_q;
        done_d    = 1'b0;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    width_d   = width_in;
                    height_d  = height_in;
                    lfsr_load = 1'b1;
                    if (dim_ok(width_in) && dim_ok(height_in)) begin
                        err_d   = 1'b0;
                        row_d   = 6'd0;
                        state_d = S_CLEAR;
                    end else begin
                        // Bitmap is left as-is so the previous maze stays on screen.
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_CLEAR: begin
                path_d[tile_idx(6'd0, row_q) +: MAZE_DIM] = '0;
                row_d = row_q + 6'd1;
                if (row_q == 6'd63) begin
                    cx_d    = 5'd0;
                    cy_d    = 5'd0;
                    state_d = S_CARVE;
                end
            end
            S_CARVE: begin
                path_d[tile_idx({cx_q, 1'b1}, {cy_q, 1'b1})] = 1'b1;
                // Top row can only link west, left column only north; the
                // origin cell links nowhere so the result is a spanning tree.
                if (cy_q == 5'd0 && cx_q == 5'd0) begin
                    path_d = path_d;
                end else if (cy_q == 5'd0 || (cx_q != 5'd0 && !north_sel)) begin
                    path_d[tile_idx({cx_q, 1'b0}, {cy_q, 1'b1})] = 1'b1;
                end else begin
                    path_d[tile_idx({cx_q, 1'b1}, {cy_q, 1'b0})] = 1'b1;
                end
                lfsr_step = 1'b1;
                if (cx_q == cx_last) begin
                    cx_d = 5'd0;
                    if (cy_q == cy_last) begin
                        state_d = S_DONE;
                    end else begin
                        cy_d = cy_q + 5'd1;
                    end
                end else begin
                    cx_d = cx_q + 5'd1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
`ifdef MAZE_EXIT_EN
                if (!err_q) begin
                    path_d[tile_idx(6'd0, 6'd1)] = 1'b1;
                    path_d[tile_idx(6'(width_q - 7'd1), 6'(height_q - 7'd2))] = 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            row_q    <= 6'd0;
            cx_q     <= 5'd0;
            cy_q     <= 5'd0;
            width_q  <= 7'd0;
            height_q <= 7'd0;
            path_q   <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            width_q  <= width_d;
            height_q <= height_d;
            path_q   <= path_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign path_data   = path_q;
    assign maze_width  = width_q;
    assign maze_height = height_q;
    assign busy        = (state_q == S_CLEAR) || (state_q == S_CARVE);
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_maze_generator.sv
// Testbench for maze_generator: directed cases plus randomized mazes, each
// checked against a cell-by-cell behavioural model of the binary-tree carve.
module tb_maze_generator;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [6:0]    width_in;
    logic [6:0]    height_in;
    logic [15:0]   seed;
    logic [4095:0] path_data;
    logic [6:0]    maze_width;
    logic [6:0]    maze_height;
    logic          busy;
    logic          done;
    logic          err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    maze_generator dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .width_in    (width_in),
        .height_in   (height_in),
        .seed        (seed),
        .path_data   (path_data),
        .maze_width  (maze_width),
        .maze_height (maze_height),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

`ifdef MAZE_EXIT_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit valid_dim(input int d);
        return (d % 2 == 1) && d >= 3 && d <= 63;
    endfunction

    // Expected bitmap: every cell opens, and each non-origin cell opens one
    // wall toward the north or west, chosen by a software Galois LFSR.
    function automatic logic [4095:0] model(input int w, input int h, input logic [15:0] sd);
        logic [4095:0] m;
        logic [15:0]   l;
        int cw, ch, tx, ty;
        m  = '0;
        l  = (sd == 16'h0000) ? 16'hACE1 : sd;
        cw = (w - 1) / 2;
        ch = (h - 1) / 2;
        for (int cy = 0; cy < ch; cy++) begin
            for (int cx = 0; cx < cw; cx++) begin
                tx = 2 * cx + 1;
                ty = 2 * cy + 1;
                m[tx + 64 * ty] = 1'b1;
                if (cy == 0 && cx > 0)       m[(tx - 1) + 64 * ty] = 1'b1;
                else if (cx == 0 && cy > 0)  m[tx + 64 * (ty - 1)] = 1'b1;
                else if (cx > 0 && cy > 0) begin
                    if (l[0]) m[tx + 64 * (ty - 1)] = 1'b1;
                    else      m[(tx - 1) + 64 * ty] = 1'b1;
                end
                l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
            end
        end
        if (EXTRA != 0) begin
            m[0 + 64 * 1] = 1'b1;
            m[(w - 1) + 64 * (h - 2)] = 1'b1;
        end
        return m;
    endfunction

    // Issue one start, watch busy/done timing, then check the final bitmap.
    // With noise set, extra start pulses are driven while busy and in DONE.
    task automatic run_maze(input string nm, input int w, input int h,
                            input logic [15:0] sd, input bit noise);
        logic [4095:0] prior, exp_map;
        int  cw, ch, n, busy_cnt, done_n, done_cnt;
        bit  ok, prev_busy;
        ok    = valid_dim(w) && valid_dim(h);
        cw    = (w - 1) / 2;
        ch    = (h - 1) / 2;
        prior = path_data;
        @(negedge clk);
        start = 1'b1; width_in = 7'(w); height_in = 7'(h); seed = sd;
        @(posedge clk); #1;
        start = 1'b0;
        check({nm, "_err"}, 64'(err), 64'(!ok));
        busy_cnt = 0; done_n = -1; done_cnt = 0; n = 0; prev_busy = 1'b0;
        while (n <= 1200) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_n < 0) done_n = n;
            end
            if (noise && (busy || prev_busy)) begin
                start     = 1'b1;
                width_in  = 7'($urandom_range(0, 127));
                height_in = 7'($urandom_range(0, 127));
                seed      = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            prev_busy = busy;
            if (done_n >= 0 && n > done_n) break;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        if (done_n < 0) begin
            check({nm, "_done_timeout"}, 64'(0), 64'(1));
        end else begin
            check({nm, "_done_cycle"}, 64'(done_n), ok ? 64'(65 + cw * ch) : 64'(1));
            check({nm, "_done_width"}, 64'(done_cnt), 64'(1));
            check({nm, "_busy_cycles"}, 64'(busy_cnt), ok ? 64'(64 + cw * ch) : 64'(0));
            check({nm, "_err_hold"}, 64'(err), 64'(!ok));
            check({nm, "_width"}, 64'(maze_width), 64'(w));
            check({nm, "_height"}, 64'(maze_height), 64'(h));
            exp_map = ok ? model(w, h, sd) : prior;
            check({nm, "_bitmap"}, 64'(path_data == exp_map), 64'(1));
            if (ok) check({nm, "_popcount"}, 64'($countones(path_data)), 64'(2 * cw * ch - 1 + EXTRA));
        end
    endtask

    initial begin : main
        int outside, w, h, sel, seen_done;
        start = 1'b0; width_in = '0; height_in = '0; seed = '0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_path", 64'(path_data == '0), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_dims", 64'({maze_width, maze_height}), 64'(0));
        @(negedge clk);
        reset = 1'b1;

        // Smallest maze: a single open cell.
        run_maze("m3x3", 3, 3, 16'h0001, 1'b0);
        check("m3x3_bit65", 64'(path_data[65]), 64'(1));

        // 5x5: fixed first-row west link and first-column north link.
        run_maze("m5x5", 5, 5, 16'h1234, 1'b0);
        check("m5x5_b65", 64'(path_data[65]), 64'(1));
        check("m5x5_b66", 64'(path_data[66]), 64'(1));
        check("m5x5_b67", 64'(path_data[67]), 64'(1));
        check("m5x5_b129", 64'(path_data[129]), 64'(1));
        check("m5x5_b193", 64'(path_data[193]), 64'(1));
        check("m5x5_b195", 64'(path_data[195]), 64'(1));
`ifdef MAZE_EXIT_EN
        check("m5x5_entr", 64'(path_data[64]), 64'(1));
        check("m5x5_exit", 64'(path_data[196]), 64'(1));
`endif

        // Invalid width: previous bitmap kept, err raised.
        run_maze("w4", 4, 5, 16'h0042, 1'b0);
        // Largest maze with seed 0 (model substitutes the default seed).
        run_maze("m63", 63, 63, 16'h0000, 1'b0);
        outside = 0;
        for (int i = 0; i < 4096; i++) begin
            if (path_data[i] && ((i % 64) >= 63 || (i / 64) >= 63)) outside++;
        end
        check("m63_border", 64'(outside), 64'(0));

        // Randomized runs, some with start noise and some invalid sizes.
        for (int it = 0; it < 10; it++) begin
            sel = $urandom_range(0, 4);
            w   = 2 * $urandom_range(1, 31) + 1;
            h   = 2 * $urandom_range(1, 31) + 1;
            if (sel == 0) w = 2 * $urandom_range(0, 40);
            if (sel == 1) h = $urandom_range(0, 1) ? 1 : 2 * $urandom_range(32, 63) + 1;
            run_maze("rand", w, h, 16'($urandom_range(0, 3) == 0 ? 0 : $urandom), 1'($urandom_range(0, 1)));
        end

        // Start pulses mid-generation are ignored; reset then aborts.
        @(negedge clk);
        start = 1'b1; width_in = 7'd63; height_in = 7'd63; seed = 16'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 150; i++) begin
            start = (i % 7 == 3); width_in = 7'd5; height_in = 7'd9; seed = 16'h0001;
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("abort_busy_before", 64'(busy), 64'(1));
        check("abort_dims_kept", 64'({maze_width, maze_height}), 64'({7'd63, 7'd63}));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("abort_path", 64'(path_data == '0), 64'(1));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_err", 64'(err), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 1100; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen_done++;
        end
        check("abort_no_done", 64'(seen_done), 64'(0));

        // Generator still works after the abort.
        run_maze("post_abort", 7, 9, 16'hBEEF, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
